// File: rtl/conv_sched_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | conv_sched_pkg: shared types for the convolution job scheduler         |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
package conv_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_START  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_RUN    = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } sched_state_e;

  typedef enum logic [1:0] {
    MOD_0 = 2'd0,
    MOD_1 = 2'd1,
    MOD_2 = 2'd2,
    MOD_3 = 2'd3
  } conv_mod_e;

  // Descriptor layout, MSB first: {mod[1:0], just_add, tag[TAG_W-1:0]}
  localparam int unsigned c_desc_fixed_w = 3;

  function automatic int unsigned desc_width(input int unsigned tag_w);
    return c_desc_fixed_w + tag_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sched_job_fifo.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | sched_job_fifo: synchronous descriptor FIFO with flush and head peek   |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module sched_job_fifo
  import conv_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w:0]   r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign full      = (r_count == (c_ptr_w + 1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign rd_data   = r_mem[r_rd_ptr];
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (w_do_push && !flush) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (c_ptr_w + 1)'(1);
        2'b01:   r_count <= r_count - (c_ptr_w + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/conv_job_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | conv_job_scheduler: queues conv job descriptors and sequences the      |
// | controller one job at a time, with watchdog and completion counting.   |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module conv_job_scheduler
  import conv_sched_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH    = 4,
  parameter int unsigned TAG_W          = 4,
  parameter int unsigned SETTLE_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [1:0]       job_mod,
  input  logic             job_just_add,
  input  logic [TAG_W-1:0] job_tag,
  input  logic             abort,
  output logic             ctrl_start,
  output logic [1:0]       ctrl_mod,
  output logic             ctrl_just_add,
  input  logic             ctrl_full_done,
  output logic             busy,
  output logic             job_done,
  output logic [TAG_W-1:0] job_done_tag,
  output logic             timeout_err,
  output logic [CNT_W-1:0] jobs_completed
);

  localparam int unsigned c_desc_w = desc_width(TAG_W);
  localparam int unsigned c_set_w  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned c_wd_w   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit          c_wd_en  = (TIMEOUT_CYCLES != 0);
  localparam logic [c_set_w-1:0] c_set_last =
      c_set_w'((SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0);
  localparam logic [c_wd_w-1:0] c_wd_last =
      c_wd_w'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  sched_state_e        r_state;
  sched_state_e        w_next;
  logic [c_set_w-1:0]  r_settle_cnt;
  logic [c_wd_w-1:0]   r_wd_cnt;
  conv_mod_e           r_ctrl_mod;
  logic                r_ctrl_ja;
  logic [TAG_W-1:0]    r_tag;
  logic [CNT_W-1:0]    r_jobs;

  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [c_desc_w-1:0] w_head;

  // A push coinciding with abort is dropped along with the flushed queue
  assign w_push = job_valid & ~w_full & ~abort;
  assign w_pop  = (r_state == ST_LOAD) & ~abort;

  sched_job_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (c_desc_w)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (w_push),
    .pop     (w_pop),
    .flush   (abort),
    .wr_data ({job_mod, job_just_add, job_tag}),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (!w_empty || w_push) w_next = ST_LOAD;
      ST_LOAD:   w_next = ST_START;
      ST_START:  w_next = (SETTLE_CYCLES == 0) ? ST_RUN : ST_SETTLE;
      ST_SETTLE: if (r_settle_cnt == c_set_last) w_next = ST_RUN;
      ST_RUN: begin
        // Completion on the terminal watchdog cycle takes precedence
        if (ctrl_full_done)                      w_next = ST_DONE;
        else if (c_wd_en && r_wd_cnt == c_wd_last) w_next = ST_ERR;
      end
      ST_DONE:   w_next = ST_IDLE;
      ST_ERR:    w_next = ST_ERR;
      default:   w_next = ST_IDLE;
    endcase
    if (abort) w_next = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_settle_cnt <= '0;
      r_wd_cnt     <= '0;
      r_ctrl_mod   <= MOD_0;
      r_ctrl_ja    <= 1'b0;
      r_tag        <= '0;
      r_jobs       <= '0;
    end else begin
      r_state <= w_next;
      if (w_pop) begin
        r_ctrl_mod <= conv_mod_e'(w_head[c_desc_w-1 -: 2]);
        r_ctrl_ja  <= w_head[TAG_W];
        r_tag      <= w_head[TAG_W-1:0];
      end
      r_settle_cnt <= (r_state == ST_SETTLE) ? r_settle_cnt + c_set_w'(1) : '0;
      r_wd_cnt     <= (r_state == ST_RUN)    ? r_wd_cnt + c_wd_w'(1)      : '0;
      if (r_state == ST_RUN && ctrl_full_done && !abort && r_jobs != '1) begin
        r_jobs <= r_jobs + CNT_W'(1);
      end
    end
  end

  assign job_ready      = ~w_full;
  assign ctrl_start     = (r_state == ST_START) & ~abort;
  assign ctrl_mod       = r_ctrl_mod;
  assign ctrl_just_add  = r_ctrl_ja;
  assign busy           = (r_state != ST_IDLE);
  assign job_done       = (r_state == ST_DONE);
  assign job_done_tag   = r_tag;
  assign timeout_err    = (r_state == ST_ERR);
  assign jobs_completed = r_jobs;

endmodule
`default_nettype wire
